// File: rtl/fiapp_pipe_if.sv
// Bundles the capture inputs and the observed pipeline outputs of fiapp_pipe.
interface fiapp_pipe_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 4
);
  logic [WIDTH-1:0] a;
  logic             enable;
  logic             flush;
  logic [WIDTH-1:0] o_first;
  logic [WIDTH-1:0] o_last;
  logic [WIDTH-1:0] o_inv;
  logic             o_valid;
  logic             o_change;
  logic [CNT_W-1:0] o_count;

  modport master (
    output a, enable, flush,
    input  o_first, o_last, o_inv, o_valid, o_change, o_count
  );

  modport slave (
    input  a, enable, flush,
    output o_first, o_last, o_inv, o_valid, o_change, o_count
  );
endinterface

// File: rtl/fiapp_pipe.sv
// Capture-and-delay pipeline: enabled capture into stage 0, fixed-depth shift,
// registered inverted tap, per-stage valid, saturating capture count, change pulse.
module fiapp_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 4
) (
  input logic         clk,
  input logic         reset,
  fiapp_pipe_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [DEPTH-1:0]            valid;
  logic [WIDTH-1:0]            inv_q;
  logic                        change_q;
  logic [CNT_W-1:0]            count_q;
  logic                        armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage    <= '0;
      valid    <= '0;
      inv_q    <= '0;
      change_q <= 1'b0;
      count_q  <= '0;
      armed    <= 1'b0;
    end else if (bus.flush) begin
      stage    <= '0;
      valid    <= '0;
      inv_q    <= '0;
      change_q <= 1'b0;
      count_q  <= '0;
      armed    <= 1'b0;
    end else begin
      if (bus.enable) begin
        stage[0] <= bus.a;
        valid[0] <= 1'b1;
        if (count_q != CNT_MAX)
          count_q <= count_q + 1'b1;
      end
      for (int unsigned i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
      valid[DEPTH-1:1] <= valid[DEPTH-2:0];
      // First edge after reset/flush keeps o_inv at 0 instead of showing ~0.
      inv_q    <= armed ? ~stage[DEPTH-2] : '0;
      armed    <= 1'b1;
      change_q <= bus.enable && (bus.a != stage[0]);
    end
  end

  assign bus.o_first  = stage[0];
  assign bus.o_last   = stage[DEPTH-1];
  assign bus.o_inv    = inv_q;
  assign bus.o_valid  = valid[DEPTH-1];
  assign bus.o_change = change_q;
  assign bus.o_count  = count_q;
endmodule
